// File: rtl/long_to_double.sv
// Signed 64-bit integer to IEEE-754 binary64 converter, round-to-nearest-even.
// Normalises one bit per cycle; single word in flight over stb/ack handshakes.
module long_to_double (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [63:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A,
        CONVERT_0,
        CONVERT_1,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_input_a_ack;
    logic               r_output_z_stb;
    logic [63:0]        r_output_z;
    logic               w_input_a_ack_nxt;
    logic               w_output_z_stb_nxt;
    logic [63:0]        w_output_z_nxt;

    logic [63:0]        r_a;
    logic [63:0]        r_value;
    logic signed [10:0] r_exp;
    logic               r_sign;
    logic [51:0]        r_frac;
    logic [63:0]        r_z;

    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_a_zero;
    logic [63:0]        w_mag;
    logic               w_guard;
    logic               w_round;
    logic               w_sticky;
    logic               w_round_up;
    logic               w_carry;
    logic [51:0]        w_frac_rounded;
    logic [10:0]        w_biased;

    assign w_in_xfer  = input_a_stb & r_input_a_ack;
    assign w_out_xfer = r_output_z_stb & output_z_ack;
    assign w_a_zero   = (r_a == '0);
    assign w_mag      = r_a[63] ? (~r_a + 64'd1) : r_a;

    // r_value[63] is the implicit leading one once normalised; the stored
    // fraction is r_value[62:11], with r_value[11] as the mantissa LSB.
    assign w_guard    = r_value[10];
    assign w_round    = r_value[9];
    assign w_sticky   = |r_value[8:0];
    assign w_round_up = w_guard & (w_round | w_sticky | r_value[11]);
    // Carry out of the 53-bit mantissa happens only when the fraction is all ones.
    assign w_carry        = w_round_up & (&r_value[62:11]);
    assign w_frac_rounded = r_value[62:11] + 52'(w_round_up);
    assign w_biased       = 11'(r_exp + 11'sd1023);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= GET_A;
            r_input_a_ack  <= 1'b0;
            r_output_z_stb <= 1'b0;
            r_output_z     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_input_a_ack  <= w_input_a_ack_nxt;
            r_output_z_stb <= w_output_z_stb_nxt;
            r_output_z     <= w_output_z_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            GET_A:     if (w_in_xfer) w_state_nxt = CONVERT_0;
            CONVERT_0: w_state_nxt = w_a_zero ? PUT_Z : CONVERT_1;
            CONVERT_1: if (r_value[63]) w_state_nxt = ROUND;
            ROUND:     w_state_nxt = PACK;
            PACK:      w_state_nxt = PUT_Z;
            PUT_Z:     if (w_out_xfer) w_state_nxt = GET_A;
            default:   w_state_nxt = GET_A;
        endcase
    end

    always_comb begin
        w_input_a_ack_nxt  = 1'b0;
        w_output_z_stb_nxt = 1'b0;
        w_output_z_nxt     = r_output_z;
        case (r_state)
            GET_A: w_input_a_ack_nxt = ~w_in_xfer;
            PUT_Z: begin
                w_output_z_stb_nxt = ~w_out_xfer;
                w_output_z_nxt     = r_z;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_value <= '0;
            r_exp   <= '0;
            r_sign  <= 1'b0;
            r_frac  <= '0;
            r_z     <= '0;
        end else begin
            case (r_state)
                GET_A: begin
                    if (w_in_xfer) r_a <= input_a;
                end
                CONVERT_0: begin
                    if (w_a_zero) begin
                        r_z <= '0;
                    end else begin
                        r_sign  <= r_a[63];
                        r_value <= w_mag;
                        r_exp   <= 11'sd63;
                    end
                end
                CONVERT_1: begin
                    if (!r_value[63]) begin
                        r_value <= {r_value[62:0], 1'b0};
                        r_exp   <= r_exp - 11'sd1;
                    end
                end
                ROUND: begin
                    r_frac <= w_carry ? '0 : w_frac_rounded;
                    if (w_carry) r_exp <= r_exp + 11'sd1;
                end
                PACK: begin
                    r_z <= {r_sign, w_biased, r_frac};
                end
                default: ;
            endcase
        end
    end

    assign input_a_ack  = r_input_a_ack;
    assign output_z_stb = r_output_z_stb;
    assign output_z     = r_output_z;

endmodule

// File: tb/tb_long_to_double.sv
// Self-checking bench for long_to_double: directed corner cases, handshake
// timing, reset abort and randomized conversions against an arithmetic model.
module tb_long_to_double;

    logic        clk;
    logic        rst;
    logic [63:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int checks;
    int failures;

    long_to_double dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int msb_pos(input logic [63:0] m);
        for (int i = 63; i >= 0; i--) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic [63:0] magnitude(input logic [63:0] a);
        return a[63] ? (64'd0 - a) : a;
    endfunction

    // Reference conversion: exact scaling for small magnitudes, otherwise
    // truncate and compare the discarded remainder with one half ulp.
    function automatic logic [63:0] ref_l2d(input logic [63:0] a);
        logic [63:0] m, q, rem, half;
        int p, sh;
        if (a == 64'd0) return 64'd0;
        m = magnitude(a);
        p = msb_pos(m);
        if (p <= 52) begin
            q = m << (52 - p);
        end else begin
            sh   = p - 52;
            q    = m >> sh;
            rem  = m & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 53)) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        return {a[63], 11'(p + 1023), q[51:0]};
    endfunction

    function automatic int ref_latency(input logic [63:0] a);
        if (a == 64'd0) return 2;
        return 68 - msb_pos(magnitude(a));
    endfunction

    // Inverse conversion, exact for magnitudes below 2^53.
    function automatic logic [63:0] ref_d2l(input logic [63:0] z);
        logic [63:0] mag;
        int e;
        if (z[62:0] == 63'd0) return 64'd0;
        e   = int'(z[62:52]) - 1023;
        mag = {11'd0, 1'b1, z[51:0]};
        if (e >= 52) mag = mag << (e - 52);
        else         mag = mag >> (52 - e);
        return z[63] ? (64'd0 - mag) : mag;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic convert(input logic [63:0] a, input int in_stall, input int out_stall,
                           output logic [63:0] z, output int lat);
        bit ok;
        z   = 'x;
        lat = -1;
        repeat (in_stall) begin @(posedge clk); #1; end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (input_a_ack) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) return;
        input_a     = a;
        input_a_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        input_a     = 64'hDEAD_BEEF_CAFE_F00D;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (output_z_stb) begin lat = n; break; end
        end
        if (lat < 0) return;
        z = output_z;
        repeat (out_stall) begin @(posedge clk); #1; end
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0 || output_z !== 64'd0) begin
            failures++;
            $display("FAIL reset_state ack=%b stb=%b z=%h required ack=0 stb=0 z=0",
                     input_a_ack, output_z_stb, output_z);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (input_a_ack !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ack got=%b required=1", input_a_ack);
        end
    endtask

    task automatic test_directed;
        logic [63:0] da [7];
        logic [63:0] dz [7];
        int          dl [7];
        logic [63:0] z;
        int          lat;
        da = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
               64'h7FFF_FFFF_FFFF_FFFF, 64'h0020_0000_0000_0001, 64'h0020_0000_0000_0003};
        dz = '{64'h0, 64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000, 64'hC3E0_0000_0000_0000,
               64'h43E0_0000_0000_0000, 64'h4340_0000_0000_0000, 64'h4340_0000_0000_0002};
        dl = '{2, 68, 68, 5, 6, 15, 15};
        for (int i = 0; i < 7; i++) begin
            convert(da[i], 0, 0, z, lat);
            checks++;
            if (z !== dz[i]) begin
                failures++;
                $display("FAIL directed_z a=%h got=%h required=%h", da[i], z, dz[i]);
            end
            checks++;
            if (lat !== dl[i]) begin
                failures++;
                $display("FAIL directed_latency a=%h got=%0d required=%0d", da[i], lat, dl[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int n;
        for (int i = 0; i < 300 && !input_a_ack; i++) begin @(posedge clk); #1; end
        input_a     = 64'd1000;
        input_a_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (output_z_stb) begin n = i; break; end
        end
        checks++;
        if (n !== 59) begin
            failures++;
            $display("FAIL bp_latency got=%0d required=59", n);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (output_z_stb !== 1'b1 || output_z !== 64'h408F_4000_0000_0000 || input_a_ack !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d stb=%b z=%h ack=%b required stb=1 z=408f400000000000 ack=0",
                         i, output_z_stb, output_z, input_a_ack);
            end
        end
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
        checks++;
        if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0) begin
            failures++;
            $display("FAIL bp_release stb=%b ack=%b required stb=0 ack=0", output_z_stb, input_a_ack);
        end
        @(posedge clk); #1;
        checks++;
        if (input_a_ack !== 1'b1 || output_z_stb !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready ack=%b stb=%b required ack=1 stb=0", input_a_ack, output_z_stb);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] a1, a2;
        int n, m;
        a1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom} >> $urandom_range(0, 63);
        for (int i = 0; i < 300 && !input_a_ack; i++) begin @(posedge clk); #1; end
        output_z_ack = 1'b1;
        input_a      = a1;
        input_a_stb  = 1'b1;
        @(posedge clk); #1;
        // Second word offered while the block is busy; it must wait, not vanish.
        input_a = a2;
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (output_z_stb) begin n = i; break; end
        end
        checks++;
        if (n !== ref_latency(a1) || output_z !== ref_l2d(a1)) begin
            failures++;
            $display("FAIL b2b_first a=%h z=%h lat=%0d required z=%h lat=%0d",
                     a1, output_z, n, ref_l2d(a1), ref_latency(a1));
        end
        m = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (i == 3) input_a_stb = 1'b0;
            if (output_z_stb) begin m = i; break; end
        end
        input_a_stb = 1'b0;
        checks++;
        if (m !== ref_latency(a2) + 3 || output_z !== ref_l2d(a2)) begin
            failures++;
            $display("FAIL b2b_second a=%h z=%h gap=%0d required z=%h gap=%0d",
                     a2, output_z, m, ref_l2d(a2), ref_latency(a2) + 3);
        end
        @(posedge clk); #1;
        output_z_ack = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit          seen;
        logic [63:0] z;
        int          lat;
        for (int i = 0; i < 300 && !input_a_ack; i++) begin @(posedge clk); #1; end
        input_a     = 64'd1;
        input_a_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid ack=%b stb=%b required ack=0 stb=0", input_a_ack, output_z_stb);
        end
        seen = 1'b0;
        output_z_ack = 1'b1;
        repeat (80) begin
            @(posedge clk); #1;
            if (output_z_stb) seen = 1'b1;
        end
        output_z_ack = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_stale stb_seen=%b required=0", seen);
        end
        convert(64'd2, 0, 0, z, lat);
        checks++;
        if (z !== 64'h4000_0000_0000_0000 || lat !== 67) begin
            failures++;
            $display("FAIL reset_mid_next z=%h lat=%0d required z=4000000000000000 lat=67", z, lat);
        end
    endtask

    task automatic test_random;
        logic [63:0] a, m, z;
        int          lat;
        for (int i = 0; i < 1000; i++) begin
            m = {$urandom, $urandom} & 64'h001F_FFFF_FFFF_FFFF;
            m = m >> $urandom_range(0, 52);
            a = $urandom_range(0, 1) ? (64'd0 - m) : m;
            convert(a, $urandom_range(0, 3), $urandom_range(0, 3), z, lat);
            checks++;
            if (z !== ref_l2d(a)) begin
                failures++;
                $display("FAIL rand_z a=%h got=%h required=%h", a, z, ref_l2d(a));
            end
            checks++;
            if (ref_d2l(z) !== a) begin
                failures++;
                $display("FAIL rand_roundtrip a=%h z=%h back=%h", a, z, ref_d2l(z));
            end
            checks++;
            if (lat !== ref_latency(a)) begin
                failures++;
                $display("FAIL rand_latency a=%h got=%0d required=%0d", a, lat, ref_latency(a));
            end
        end
        for (int i = 0; i < 200; i++) begin
            a = {$urandom, $urandom};
            convert(a, $urandom_range(0, 2), $urandom_range(0, 2), z, lat);
            checks++;
            if (z !== ref_l2d(a) || lat !== ref_latency(a)) begin
                failures++;
                $display("FAIL wide_z a=%h got=%h lat=%0d required=%h lat=%0d",
                         a, z, lat, ref_l2d(a), ref_latency(a));
            end
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        input_a      = 64'd0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
